// File: rtl/ac_pkg.sv
// Shared constants and state encoding for the Aho-Corasick text streamer and matcher.
package ac_pkg;

  localparam int CHAR_W = 8;
  localparam int DEPTH  = 32;
  localparam int AW     = 5;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_PRIME  = 3'd1;
  localparam state_t S_SEND   = 3'd2;
  localparam state_t S_GAP    = 3'd3;
  localparam state_t S_FINISH = 3'd4;

endpackage

// File: rtl/ac_char_fifo.sv
// Circular character buffer with registered occupancy flags and a sticky overflow bit.
module ac_char_fifo
  import ac_pkg::*;
#(
  parameter int DEPTH_P  = DEPTH,
  parameter int AW_P     = AW,
  parameter int CHAR_W_P = CHAR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [CHAR_W_P-1:0] wr_data,
  input  logic                pop,
  output logic [CHAR_W_P-1:0] head,
  output logic                full,
  output logic                empty,
  output logic [AW_P:0]       count,
  output logic                overflow
);

  logic [CHAR_W_P-1:0] mem [DEPTH_P];
  logic [AW_P-1:0]     wr_ptr;
  logic [AW_P-1:0]     rd_ptr;
  logic [AW_P:0]       count_nxt;
  logic                wr_ok;

  // A pop in the same cycle frees a slot, so a write while full is still accepted.
  assign wr_ok = wr_en && (!full || pop);
  assign head  = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (wr_ok && !pop)
      count_nxt = count + 1'b1;
    else if (!wr_ok && pop)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (AW_P+1)'(DEPTH_P));
      empty <= (count_nxt == '0);
      if (wr_en && !wr_ok)
        overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/ac_text_streamer.sv
// Replays buffered host characters to the matcher as INITIALIZE/EN two-phase steps.
//
// state  | meaning
// IDLE   | waiting for START
// PRIME  | first INITIALIZE phase of a frame (held by PAUSE)
// SEND   | EN high, STRING carries the popped character
// GAP    | INITIALIZE phase between characters (held by PAUSE)
// FINISH | DONE pulse, then back to IDLE
module ac_text_streamer
  import ac_pkg::*;
#(
  parameter int DEPTH_P  = DEPTH,
  parameter int AW_P     = AW,
  parameter int CHAR_W_P = CHAR_W
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                WR_EN,
  input  logic [CHAR_W_P-1:0] WR_DATA,
  output logic                FULL,
  output logic                EMPTY,
  output logic [AW_P:0]       COUNT,
  output logic                OVERFLOW,
  input  logic                START,
  input  logic                PAUSE,
  output logic                BUSY,
  output logic                DONE,
  output logic [CHAR_W_P-1:0] STRING,
  output logic                EN,
  output logic                INITIALIZE
);

  state_t              state_q;
  state_t              state_d;
  logic [AW_P:0]       len_q;
  logic [AW_P:0]       len_d;
  logic                pop;
  logic [CHAR_W_P-1:0] head;

  ac_char_fifo #(
    .DEPTH_P  (DEPTH_P),
    .AW_P     (AW_P),
    .CHAR_W_P (CHAR_W_P)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .wr_en    (WR_EN),
    .wr_data  (WR_DATA),
    .pop      (pop),
    .head     (head),
    .full     (FULL),
    .empty    (EMPTY),
    .count    (COUNT),
    .overflow (OVERFLOW)
  );

  // Outputs are registered from the next state, so the pop and LEN decrement
  // happen on the edge that enters SEND, with STRING loaded on that same edge.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          if (COUNT != '0) begin
            len_d   = COUNT;
            state_d = S_PRIME;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_PRIME, S_GAP: begin
        if (!PAUSE) begin
          len_d   = len_q - 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND:   state_d = (len_q == '0) ? S_FINISH : S_GAP;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign pop = (state_d == S_SEND);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      STRING     <= '0;
      EN         <= 1'b0;
      INITIALIZE <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      BUSY       <= (state_d != S_IDLE);
      DONE       <= (state_d == S_FINISH);
      EN         <= (state_d == S_SEND);
      INITIALIZE <= (state_d == S_PRIME) || (state_d == S_GAP);
      if (state_d == S_SEND)
        STRING <= head;
    end
  end

endmodule

// File: tb/tb_ac_text_streamer.sv
// Randomized self-checking bench for ac_text_streamer against a queue-based frame model.
module tb_ac_text_streamer;
  import ac_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       WR_EN = 1'b0;
  logic [7:0] WR_DATA = '0;
  logic       START = 1'b0;
  logic       PAUSE = 1'b0;
  logic       FULL, EMPTY, OVERFLOW, BUSY, DONE, EN, INITIALIZE;
  logic [5:0] COUNT;
  logic [7:0] STRING;

  ac_text_streamer dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_DATA(WR_DATA),
    .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT), .OVERFLOW(OVERFLOW),
    .START(START), .PAUSE(PAUSE), .BUSY(BUSY), .DONE(DONE),
    .STRING(STRING), .EN(EN), .INITIALIZE(INITIALIZE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       init;
    logic       en;
    logic       done;
    logic [7:0] str;
    logic       pause;
    logic       wr;
    logic [7:0] wdata;
  } rec_t;

  logic [7:0] model_q[$];
  logic       model_ovf;
  logic [7:0] last_str;
  int         vectors;
  int         miscompares;

  task automatic test_reset();
    RST = 1'b1; WR_EN = 1'b0; START = 1'b0; PAUSE = 1'b0;
    @(negedge CLK);
    model_q.delete(); model_ovf = 1'b0; last_str = 8'h00;
    vectors++;
    if ({FULL, EMPTY, COUNT, OVERFLOW, BUSY, DONE, STRING, EN, INITIALIZE} !== {1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: got F%b E%b C%0d O%b B%b D%b S%h EN%b I%b, want F0 E1 C0 O0 B0 D0 S00 EN0 I0",
               FULL, EMPTY, COUNT, OVERFLOW, BUSY, DONE, STRING, EN, INITIALIZE);
    end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic write_bytes(input string name, input int n, input bit rnd, input logic [7:0] base);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = rnd ? 8'($urandom) : base + 8'(i);
      WR_EN = 1'b1; WR_DATA = d;
      if (model_q.size() < 32) model_q.push_back(d);
      else model_ovf = 1'b1;
      @(negedge CLK);
    end
    WR_EN = 1'b0;
    @(negedge CLK);
    vectors++;
    if (COUNT !== 6'(model_q.size())) begin
      miscompares++;
      $display("FAIL %s count: got %0d want %0d", name, COUNT, model_q.size());
    end
    vectors++;
    if ({FULL, EMPTY, OVERFLOW} !== {model_q.size() == 32, model_q.size() == 0, model_ovf}) begin
      miscompares++;
      $display("FAIL %s flags FEO: got %b%b%b want %b%b%b", name, FULL, EMPTY, OVERFLOW,
               model_q.size() == 32, model_q.size() == 0, model_ovf);
    end
  endtask

  // max_pause: random PAUSE length per INITIALIZE phase; gap1: fixed pause on first gap (-1 = random)
  task automatic run_frame(input string name, input int max_pause, input int gap1,
                           input int n_wr, input logic [7:0] wbase);
    rec_t       exp_q[$];
    rec_t       r;
    logic [7:0] wq[$];
    int         n, p, first_wr;
    n = model_q.size();
    if (n == 0) begin
      exp_q.push_back('{1'b0, 1'b0, 1'b1, last_str, 1'b0, 1'b0, 8'h00});
    end else begin
      for (int i = 0; i < n; i++) begin
        if (gap1 >= 0) p = (i == 1) ? gap1 : 0;
        else p = $urandom_range(0, max_pause);
        for (int k = 0; k <= p; k++)
          exp_q.push_back('{1'b1, 1'b0, 1'b0, last_str, (k < p), 1'b0, 8'h00});
        last_str = model_q[i];
        exp_q.push_back('{1'b0, 1'b1, 1'b0, last_str,
                          (max_pause > 0) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, 8'h00});
      end
      exp_q.push_back('{1'b0, 1'b0, 1'b1, last_str, 1'b0, 1'b0, 8'h00});
      first_wr = exp_q.size() - 1 - n_wr;
      for (int k = 0; k < n_wr; k++) begin
        exp_q[first_wr + k].wr    = 1'b1;
        exp_q[first_wr + k].wdata = wbase + 8'(k);
        wq.push_back(wbase + 8'(k));
      end
    end
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (int idx = 0; idx < exp_q.size(); idx++) begin
      r = exp_q[idx];
      vectors++;
      if ({INITIALIZE, EN, DONE, BUSY} !== {r.init, r.en, r.done, 1'b1}) begin
        miscompares++;
        $display("FAIL %s cyc%0d I/EN/DONE/BUSY: got %b%b%b%b want %b%b%b1", name, idx,
                 INITIALIZE, EN, DONE, BUSY, r.init, r.en, r.done);
      end
      vectors++;
      if (STRING !== r.str) begin
        miscompares++;
        $display("FAIL %s cyc%0d string: got %h want %h", name, idx, STRING, r.str);
      end
      PAUSE = r.pause; WR_EN = r.wr; WR_DATA = r.wdata;
      @(negedge CLK);
    end
    PAUSE = 1'b0; WR_EN = 1'b0;
    model_q = wq;
    vectors++;
    if ({BUSY, DONE, EN, INITIALIZE, EMPTY} !== {4'b0000, model_q.size() == 0}) begin
      miscompares++;
      $display("FAIL %s idle after: got B%b D%b EN%b I%b E%b want B0 D0 EN0 I0 E%b", name,
               BUSY, DONE, EN, INITIALIZE, EMPTY, model_q.size() == 0);
    end
    vectors++;
    if (COUNT !== 6'(model_q.size())) begin
      miscompares++;
      $display("FAIL %s count after: got %0d want %0d", name, COUNT, model_q.size());
    end
  endtask

  task automatic test_basic();
    write_bytes("basic_wr", 8, 1'b0, 8'h61);
    run_frame("basic", 0, -1, 0, 8'h00);
  endtask

  task automatic test_empty_start();
    run_frame("empty", 0, -1, 0, 8'h00);
  endtask

  task automatic test_overflow();
    write_bytes("ovf_wr", 33, 1'b0, 8'h20);
    run_frame("ovf", 0, -1, 0, 8'h00);
  endtask

  task automatic test_pause();
    write_bytes("pause_wr", 3, 1'b1, 8'h00);
    run_frame("pause", 0, 4, 0, 8'h00);
  endtask

  task automatic test_write_during();
    write_bytes("wdur_wr", 2, 1'b1, 8'h00);
    run_frame("wdur", 0, -1, 1, 8'h7A);
    run_frame("wdur_next", 0, -1, 0, 8'h00);
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 12; it++) begin
      n = $urandom_range(0, 32 - model_q.size());
      write_bytes("rnd_wr", n, 1'b1, 8'h00);
      run_frame("rnd", 2, -1, (model_q.size() > 0) ? $urandom_range(0, 2) : 0, 8'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    write_bytes("rmid_wr", 5, 1'b1, 8'h00);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (4) @(negedge CLK);
    vectors++;
    if ({INITIALIZE, EN, BUSY} !== 3'b101) begin
      miscompares++;
      $display("FAIL rmid in_gap: got I%b EN%b B%b want I1 EN0 B1", INITIALIZE, EN, BUSY);
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    model_q.delete(); model_ovf = 1'b0; last_str = 8'h00;
    vectors++;
    if ({FULL, EMPTY, COUNT, OVERFLOW, BUSY, DONE, STRING, EN, INITIALIZE} !== {1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL rmid reset: got F%b E%b C%0d O%b B%b D%b S%h EN%b I%b", FULL, EMPTY, COUNT,
               OVERFLOW, BUSY, DONE, STRING, EN, INITIALIZE);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      vectors++;
      if ({DONE, BUSY, EN, INITIALIZE} !== 4'b0000) begin
        miscompares++;
        $display("FAIL rmid quiet%0d: got D%b B%b EN%b I%b want 0000", k, DONE, BUSY, EN, INITIALIZE);
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    model_ovf = 1'b0; last_str = 8'h00;
    test_reset();
    test_basic();
    test_empty_start();
    test_overflow();
    test_pause();
    test_write_during();
    test_random();
    test_reset_mid();
    test_basic();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
